// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Serial transmit stage that drains a first-word-fall-through byte FIFO.
// Each word is popped with a one-cycle fifo_rd_en strobe and sent on tx as an
// asynchronous character: start bit (0), data bits LSB-first, an optional even
// parity bit, then STOP_BITS stop bits (1).
//
// Optional feature macro: FIFO_UART_TX_PARITY_EN
//   defined   -> one even-parity bit is sent after the data bits
//   undefined -> no parity state or logic; data goes straight to stop
//
// Parameters:
//   DATA_WIDTH   - FIFO word width and data bits per frame
//   CLKS_PER_BIT - clk cycles per serial bit (>= 2)
//   STOP_BITS    - number of stop bits (1 or 2)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   enable     in   permits starting new frames (sampled only in IDLE)
//   fifo_empty in   FIFO empty flag
//   fifo_data  in   FIFO head word, valid while fifo_empty is low
//   fifo_rd_en out  pop strobe, one cycle per frame, only from IDLE
//   tx         out  registered serial line, idles high
//   busy       out  high while a frame is in progress
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  tx_next;
  logic                  last_cnt;

`ifdef FIFO_UART_TX_PARITY_EN
  logic parity, parity_next;
`endif

  // The pop strobe is gated by reset as well, so a held reset never pops a
  // word even though the state register already reads IDLE.
  assign fifo_rd_en = (state == IDLE) & enable & ~fifo_empty & ~reset;
  assign busy       = (state != IDLE);
  assign last_cnt   = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // State, counters, shift register and the tx flop. tx is computed from the
  // next state so the line changes exactly on bit boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
      parity    <= parity_next;
`endif
    end
  end

  // Next-state logic. idx counts data bits in DATA and stop bits in STOP;
  // cnt clears on every bit or state transition and never wraps on its own.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift_reg;
    tx_next    = tx;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_next = parity;
`endif

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (fifo_rd_en) begin
          state_next = START;
          shift_next = fifo_data;
          cnt_next   = '0;
          idx_next   = '0;
          tx_next    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_next = ^fifo_data;
`endif
        end
      end

      START: begin
        if (last_cnt) begin
          state_next = DATA;
          cnt_next   = '0;
          tx_next    = shift_reg[0];
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      DATA: begin
        if (last_cnt) begin
          cnt_next = '0;
          if (idx == IDX_W'(DATA_WIDTH - 1)) begin
            idx_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            shift_next = shift_reg >> 1;
            idx_next   = idx + 1'b1;
            tx_next    = shift_next[0];
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (last_cnt) begin
          state_next = STOP;
          cnt_next   = '0;
          idx_next   = '0;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`endif

      STOP: begin
        tx_next = 1'b1;
        if (last_cnt) begin
          cnt_next = '0;
          if (idx == IDX_W'(STOP_BITS - 1)) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the byte FIFO. It pops one word at a time through the FIFO's read handshake and frames each word as an asynchronous serial character: start bit, data LSB-first, optional parity, stop bit(s). It sits directly downstream of the FIFO and drives the device's serial TX pin.

## Interface
- `DATA_WIDTH`, 8: width of each FIFO word; equals the number of data bits per frame.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; must be ≥ 2.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits starting new frames; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO head word; valid whenever `fifo_empty` is low (first-word-fall-through).
- `fifo_rd_en`  out  1  pop strobe to the FIFO; one-cycle pulse per frame.
- `tx`  out  1  serial line, registered; idles high.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: `fifo_rd_en = enable & ~fifo_empty` (combinational from registered state). On that edge, latch `fifo_data` into the shift register and go to START.
- START: `tx = 0` for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive the shift register LSB for CLKS_PER_BIT cycles per bit, then shift right; a bit index counts from 0 to DATA_WIDTH-1. After the last bit, go to PARITY, or to STOP when parity is compiled out.
- PARITY: `tx` = XOR of the latched word (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx = 1` for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
- Bit-time counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and clears on every state or bit transition.
  - No wrap beyond the terminal count.
- Bit index width is $clog2(DATA_WIDTH)+1.
- `enable` low mid-frame: the current frame completes normally; no new pop occurs.
- `fifo_empty` high in IDLE: no pop; `tx` stays high.
- `fifo_rd_en` never asserts outside IDLE, so the block never pops a word while a frame is in flight.
- Reset mid-frame: the frame is aborted and the latched word is discarded (lost). After release, the block resumes from IDLE with the next FIFO word.

## Timing
- Reset values: `tx = 1`, `fifo_rd_en = 0`, `busy = 0`, state = IDLE, counters = 0, shift register = 0.
- Pop to line: the start bit appears on `tx` the cycle after the `fifo_rd_en` cycle, and `busy` rises on the same cycle.
- Frame length is N×CLKS_PER_BIT cycles, where N = 1 + DATA_WIDTH + STOP_BITS (+1 with parity).
- Back-to-back frames: exactly one IDLE cycle (`tx = 1`, pop cycle) between the end of the last stop bit and the next start bit.
- Pop period under continuous data is N×CLKS_PER_BIT + 1 cycles.
- `tx` changes only at bit boundaries; it is glitch-free because it is registered.

## Configuration
- Macro: `FIFO_UART_TX_PARITY_EN`.
- Defined: the PARITY state is present, frames carry one even-parity bit after the data bits, and N includes +1.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

## Test plan
1. Reset with `fifo_empty` low and `enable` high:
   - During reset: `tx = 1`, `fifo_rd_en = 0`, `busy = 0`.
   - First pop occurs on the first edge after release.
2. CLKS_PER_BIT=4, one word 0xA5, no parity:
   - Single `fifo_rd_en` pulse.
   - `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
   - `busy` is high for exactly 40 cycles.
   - With `FIFO_UART_TX_PARITY_EN` defined: a parity bit of 0 is inserted before stop, and `busy` is high for 44 cycles.
3. FIFO holding 0x01, 0x02, 0x03 with `enable` held high:
   - Three `fifo_rd_en` pulses spaced 41 cycles apart.
   - One high idle cycle between frames.
   - Decoded bytes are 0x01, 0x02, 0x03.
4. `enable` dropped during data bit 3 of 0x5A:
   - The frame completes intact.
   - No further `fifo_rd_en` while `enable` is low.
   - Pops resume one cycle after `enable` returns high in IDLE.
5. `reset` pulsed during data bit 5:
   - `tx` goes high immediately, without waiting for a clock edge.
   - `busy` goes to 0.
   - After release, the next FIFO word is popped and sent with a full, correct frame.
6. `fifo_empty` held high for 200 cycles with `enable` high:
   - `fifo_rd_en = 0`, `tx = 1` and `busy = 0` throughout.
